// File: rtl/can_tx_bit_stuffer.sv
// CAN transmit bit stuffer: inserts stuff bits into the outgoing stream and monitors the bus.
// Define CAN_TX_BIT_MONITOR_EN to build in the bit monitor, bit_error/arb_lost and BACKOFF.
module can_tx_bit_stuffer (
  input  logic clk,
  input  logic rst,
  input  logic sample_point,
  input  logic bit_start_point,
  input  logic tx_active,
  input  logic tx_bit,
  input  logic bit_stuffing_en,
  input  logic arbitration_active,
  input  logic rx_bit,
  output logic can_tx,
  output logic insert_stuff_bit,
  output logic stuff_bit_active,
  output logic bit_error,
  output logic arb_lost
);

  typedef enum logic [1:0] {StIdle, StData, StStuff, StBackoff} state_e;

  state_e     state_q, state_d;
  logic [2:0] run_cnt_q, run_cnt_d;
  logic       last_bit_q, last_bit_d;
  logic       can_tx_q, can_tx_d;
  logic       ins_q, ins_d;
  logic       stuff_q, stuff_d;
  logic       bit_err_d, arb_lost_d;
  logic       do_launch, do_stuff;

  // A pending stuff request wins over launching the held transmitter bit.
  assign do_stuff  = bit_start_point && tx_active && (state_q == StData) && ins_q;
  assign do_launch = bit_start_point && tx_active &&
                     ((state_q == StIdle) || (state_q == StStuff) ||
                      ((state_q == StData) && !ins_q));

  always_comb begin
    state_d    = state_q;
    run_cnt_d  = run_cnt_q;
    last_bit_d = last_bit_q;
    can_tx_d   = can_tx_q;
    bit_err_d  = 1'b0;
    arb_lost_d = 1'b0;

`ifdef CAN_TX_BIT_MONITOR_EN
    // Compares against can_tx_q, i.e. the level driven before any same-cycle launch.
    if (sample_point && ((state_q == StData) || (state_q == StStuff)) &&
        (rx_bit != can_tx_q)) begin
      if (arbitration_active && can_tx_q && !rx_bit && (state_q == StData)) begin
        arb_lost_d = 1'b1;
      end else begin
        bit_err_d = 1'b1;
      end
    end
`endif

    if (do_launch) begin
      state_d  = StData;
      can_tx_d = tx_bit;
      if (bit_stuffing_en) begin
        run_cnt_d  = ((tx_bit == last_bit_q) && (run_cnt_q != 3'd0)) ? run_cnt_q + 3'd1 : 3'd1;
        last_bit_d = tx_bit;
      end else begin
        run_cnt_d = 3'd0;
      end
    end else if (do_stuff) begin
      state_d    = StStuff;
      can_tx_d   = ~last_bit_q;
      last_bit_d = ~last_bit_q;
      run_cnt_d  = 3'd1;
    end

`ifdef CAN_TX_BIT_MONITOR_EN
    if (arb_lost_d) begin
      state_d   = StBackoff;
      can_tx_d  = 1'b1;
      run_cnt_d = 3'd0;
    end
    if ((state_q == StBackoff) && !tx_active) begin
      state_d    = StIdle;
      can_tx_d   = 1'b1;
      run_cnt_d  = 3'd0;
      last_bit_d = 1'b1;
    end
`endif

    if (bit_start_point && !tx_active) begin
      state_d    = StIdle;
      can_tx_d   = 1'b1;
      run_cnt_d  = 3'd0;
      last_bit_d = 1'b1;
    end

    ins_d   = (state_d == StData) && (run_cnt_d == 3'd5);
    stuff_d = (state_d == StStuff);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      run_cnt_q  <= 3'd0;
      last_bit_q <= 1'b1;
      can_tx_q   <= 1'b1;
      ins_q      <= 1'b0;
      stuff_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      run_cnt_q  <= run_cnt_d;
      last_bit_q <= last_bit_d;
      can_tx_q   <= can_tx_d;
      ins_q      <= ins_d;
      stuff_q    <= stuff_d;
    end
  end

  assign can_tx           = can_tx_q;
  assign insert_stuff_bit = ins_q;
  assign stuff_bit_active = stuff_q;

`ifdef CAN_TX_BIT_MONITOR_EN
  logic bit_err_q, arb_lost_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      bit_err_q  <= 1'b0;
      arb_lost_q <= 1'b0;
    end else begin
      bit_err_q  <= bit_err_d;
      arb_lost_q <= arb_lost_d;
    end
  end

  assign bit_error = bit_err_q;
  assign arb_lost  = arb_lost_q;
`else
  logic unused_monitor;
  assign unused_monitor = ^{sample_point, rx_bit, arbitration_active, bit_err_d, arb_lost_d};
  assign bit_error = 1'b0;
  assign arb_lost  = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_bit_stuffer.sv
// Randomized bench for can_tx_bit_stuffer: frames are stuffed by a queue-based reference
// model and the bus stream, stuff flags and monitor pulses are compared bit time by bit time.
module tb_can_tx_bit_stuffer;

`ifdef CAN_TX_BIT_MONITOR_EN
  localparam bit MonEn = 1'b1;
`else
  localparam bit MonEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, sample_point, bit_start_point, tx_active, tx_bit, bit_stuffing_en;
  logic arbitration_active, rx_bit;
  logic can_tx, insert_stuff_bit, stuff_bit_active, bit_error, arb_lost;

  int n_tests = 0;
  int n_fail  = 0;

  logic data_q[$];
  logic en_q[$];
  logic bus_q[$];
  logic stf_q[$];
  int   idx_q[$];

  always #5 clk = ~clk;

  can_tx_bit_stuffer dut (
    .clk               (clk),
    .rst               (rst),
    .sample_point      (sample_point),
    .bit_start_point   (bit_start_point),
    .tx_active         (tx_active),
    .tx_bit            (tx_bit),
    .bit_stuffing_en   (bit_stuffing_en),
    .arbitration_active(arbitration_active),
    .rx_bit            (rx_bit),
    .can_tx            (can_tx),
    .insert_stuff_bit  (insert_stuff_bit),
    .stuff_bit_active  (stuff_bit_active),
    .bit_error         (bit_error),
    .arb_lost          (arb_lost)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: walk the data bits, append a complement bit after any five equal
  // stuffed-region bus bits; the inserted bit starts the next run.
  function automatic void build_bus();
    int   run  = 0;
    logic last = 1'b1;
    bus_q.delete();
    stf_q.delete();
    idx_q.delete();
    for (int i = 0; i < data_q.size(); i++) begin
      bus_q.push_back(data_q[i]);
      stf_q.push_back(1'b0);
      idx_q.push_back(i);
      if (en_q[i]) begin
        run  = (data_q[i] == last && run != 0) ? run + 1 : 1;
        last = data_q[i];
      end else begin
        run = 0;
      end
      if (run == 5) begin
        bus_q.push_back(~last);
        stf_q.push_back(1'b1);
        idx_q.push_back(i + 1);
        last = ~last;
        run  = 1;
      end
    end
  endfunction

  // One bit time of 8 cycles: bit_start in cycle 0, sample_point in cycle 5.
  task automatic run_slot(input logic txb, input logic en, input logic arb, input logic act,
                          input logic exp_bus, input logic exp_stf, input logic exp_ins,
                          input logic flip, input int exp_berr, input int exp_arb);
    int nerr = 0;
    int narb = 0;
    bit_start_point    = 1'b1;
    tx_active          = act;
    tx_bit             = txb;
    bit_stuffing_en    = en;
    arbitration_active = arb;
    sample_point       = 1'b0;
    rx_bit             = exp_bus;
    @(posedge clk);
    #1;
    bit_start_point = 1'b0;
    for (int p = 1; p < 8; p++) begin
      if (p == 1) begin
        check_eq("can_tx", int'(can_tx), int'(exp_bus));
        check_eq("stuff_bit_active", int'(stuff_bit_active), int'(exp_stf));
        check_eq("insert_stuff_bit", int'(insert_stuff_bit), int'(exp_ins));
      end
      sample_point = (p == 5);
      rx_bit       = (p == 5) ? (exp_bus ^ flip) : exp_bus;
      @(posedge clk);
      #1;
      nerr += int'(bit_error);
      narb += int'(arb_lost);
    end
    sample_point = 1'b0;
    check_eq("bit_error_pulses", nerr, exp_berr);
    check_eq("arb_lost_pulses", narb, exp_arb);
  endtask

  task automatic idle_slot();
    // Monitor must ignore a mismatching sample while idle.
    run_slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
  endtask

  task automatic run_frame(input int flip_pct);
    logic flip;
    logic nxt;
    build_bus();
    for (int i = 0; i < bus_q.size(); i++) begin
      flip = ($urandom_range(0, 99) < flip_pct);
      nxt  = (i + 1 < bus_q.size()) ? stf_q[i + 1] : 1'b0;
      run_slot(data_q[idx_q[i]], en_q[idx_q[i]], 1'b0, 1'b1, bus_q[i], stf_q[i], nxt,
               flip, MonEn ? int'(flip) : 0, 0);
    end
    idle_slot();
  endtask

  task automatic load(input string bits, input int region);
    data_q.delete();
    en_q.delete();
    for (int i = 0; i < bits.len(); i++) begin
      data_q.push_back(bits[i] == "1");
      en_q.push_back(i < region);
    end
  endtask

  initial begin
    rst = 1'b1; sample_point = 1'b0; bit_start_point = 1'b0; tx_active = 1'b0;
    tx_bit = 1'b1; bit_stuffing_en = 1'b0; arbitration_active = 1'b0; rx_bit = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_can_tx", int'(can_tx), 1);
    check_eq("rst_insert_stuff_bit", int'(insert_stuff_bit), 0);
    check_eq("rst_stuff_bit_active", int'(stuff_bit_active), 0);
    check_eq("rst_bit_error", int'(bit_error), 0);
    check_eq("rst_arb_lost", int'(arb_lost), 0);
    rst = 1'b0;
    idle_slot();

    // Five dominant bits, then a new run started by the stuff bit.
    load("0000011110111111", 9);
    run_frame(0);
    // Region ends on the fifth identical bit: stuff still inserted, tail never stuffed.
    load("0111111111111", 6);
    run_frame(0);
    // Bit errors on data and stuff bits.
    load("00000111100000", 10);
    run_frame(40);

    // Arbitration loss on a recessive arbitration bit.
    run_slot(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    run_slot(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 0, MonEn ? 1 : 0);
    run_slot(1'b0, 1'b1, 1'b1, 1'b1, MonEn ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b1, 0, 0);
    run_slot(1'b0, 1'b1, 1'b1, 1'b1, MonEn ? 1'b1 : 1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
    idle_slot();

    // Reset during a stuff request, then a fresh frame must start its run from zero.
    for (int i = 0; i < 5; i++) begin
      run_slot(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, (i == 4), 1'b0, 0, 0);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_can_tx", int'(can_tx), 1);
    check_eq("midrst_insert_stuff_bit", int'(insert_stuff_bit), 0);
    rst = 1'b0;
    load("0000111111", 6);
    run_frame(0);

    // Randomized frames with run-biased bits and occasional monitor mismatches.
    for (int f = 0; f < 25; f++) begin
      int   region = $urandom_range(5, 30);
      int   tail   = $urandom_range(3, 10);
      logic b      = 1'b0;
      data_q.delete();
      en_q.delete();
      for (int i = 0; i < region + tail; i++) begin
        if (i > 0 && $urandom_range(0, 9) >= 7) b = ~b;
        data_q.push_back((i < region) ? b : 1'($urandom_range(0, 1)));
        en_q.push_back(i < region);
      end
      run_frame((f % 3 == 0) ? 15 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
